mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between the core's instruction-fetch path and its load/store path.
- Sits between the data path's fetch and data memory interfaces and the unified memory.
- Serialises requests with round-robin fairness, holds the memory bus stable until the memory signals ready, and returns read data with a one-cycle ack pulse.
- A watchdog aborts any access that the memory never completes.

Parameters:
WIDTH, 32, address and data width
TIMEOUT, 16, max cycles mem_en may stay high without mem_ready before abort (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held with if_addr until if_ack
if_addr  input  WIDTH  fetch address
if_rdata  output  WIDTH  fetched word
if_ack  output  1  one-cycle completion pulse for fetch
if_err  output  1  fetch timed out; valid only with if_ack
d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  WIDTH  data address
d_wdata  input  WIDTH  store data
d_be  input  4  byte enables (byte/half/word)
d_rdata  output  WIDTH  load data
d_ack  output  1  one-cycle completion pulse for data
d_err  output  1  data access timed out; valid only with d_ack
mem_en  output  1  memory access active
mem_we  output  1  memory write
mem_addr  output  WIDTH  memory address
mem_wdata  output  WIDTH  memory write data
mem_be  output  4  memory byte enables
mem_rdata  input  WIDTH  memory read data, valid with mem_ready
mem_ready  input  1  memory completes current access at this edge
busy  output  1  high while in BUSY_I or BUSY_D

Behaviour:
- Reset (reset=0, async):
  - State=IDLE, last_grant=DATA, timeout counter=0.
  - All outputs 0, including rdata registers and mem_* buses.
  - Any in-flight access is dropped with no ack.
- All outputs are registered.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Effective requests: if_req_m = if_req & ~if_ack; d_req_m = d_req & ~d_ack. A requester seeing its own ack is never re-granted in the same cycle.
  - Only one masked request: grant it.
  - Both masked requests: grant the port that is not last_grant. From reset, fetch wins first.
  - On the grant edge:
    - Load mem_addr.
    - Fetch: mem_we=0, mem_be=4'b1111, mem_wdata unchanged.
    - Data: load mem_we, mem_wdata, mem_be from the d_* inputs.
    - Set mem_en=1, update last_grant, clear counter, enter BUSY_x.
- BUSY_x:
  - mem_* are held constant.
  - Counter increments every cycle mem_ready=0.
  - If mem_ready=1 at an edge:
    - mem_en<=0, mem_we<=0.
    - Pulse x_ack=1 for exactly one cycle, x_err=0.
    - Read (fetch or load): x_rdata<=mem_rdata.
    - Store: d_rdata unchanged.
    - Return to IDLE.
  - Else if counter reaches TIMEOUT-1:
    - mem_en<=0, mem_we<=0.
    - x_ack=1, x_err=1, x_rdata<=0.
    - Return to IDLE.
  - mem_ready wins if it coincides with the timeout.
  - x_req dropping mid-access is ignored: the access completes and ack still pulses.
  - The other port's request waits; no preemption.
- Latency: req seen at edge N (IDLE) -> mem_en high after N. mem_ready at edge N+k (k>=1) -> ack and rdata visible after N+k.
  - Minimum 2 cycles req-to-ack.
  - Minimum 3 cycles between successive grants of the same port (ack cycle is masked).
- x_rdata holds its value until the next ack on that port.
- mem_ready while IDLE is ignored.
- busy = (state != IDLE).

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x100; memory returns 0x00500093 with mem_ready one cycle after mem_en. Required: mem_en=1, mem_we=0, mem_be=4'hF; if_ack one cycle, 2 cycles after req, if_rdata=0x00500093; busy returns 0.
- Store byte: d_we=1, d_addr=0x204, d_wdata=0xAB, d_be=4'b0001, mem_ready after 3 cycles. Required: mem_* stable all 3 cycles; d_ack=1 with d_err=0; d_rdata unchanged.
- Simultaneous if_req and d_req after reset, each held. Required grant order fetch, data, then fetch again (round-robin). No port is granted in its own ack cycle.
- Memory never asserts mem_ready, TIMEOUT=16. Required: after 16 cycles mem_en=0; if_ack=1 with if_err=1 and if_rdata=0; next request is accepted normally.
- Drive reset=0 asynchronously mid BUSY_D. Required: all outputs 0 immediately, no d_ack. After release, a pending if_req is granted first.
- mem_ready pulsed while IDLE, and d_req dropped mid-access. Required: IDLE ignores the pulse; the mid-access drop still yields exactly one d_ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// All outputs are registered; a watchdog aborts accesses the memory never completes.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ack,
    output logic             if_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [3:0]       d_be,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ack,
    output logic             d_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} stateType;

    stateType state, nextState;
    logic             lastGrantData, lastGrantNxt;
    logic [CW-1:0]    cnt, cntNxt;
    logic             ifReqM, dReqM, grantI, grantD, timeoutHit;

    logic [WIDTH-1:0] ifRdataNxt, dRdataNxt, memAddrNxt, memWdataNxt;
    logic             ifAckNxt, ifErrNxt, dAckNxt, dErrNxt;
    logic             memEnNxt, memWeNxt, busyNxt;
    logic [3:0]       memBeNxt;

    // A port whose ack is currently visible is masked so it cannot be re-granted at once.
    always_comb begin
        ifReqM     = if_req & ~if_ack;
        dReqM      = d_req & ~d_ack;
        grantI     = ifReqM & (~dReqM | lastGrantData);
        grantD     = dReqM & ~grantI;
        timeoutHit = (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantI)      nextState = BUSY_I;
                else if (grantD) nextState = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || timeoutHit) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        ifRdataNxt   = if_rdata;
        dRdataNxt    = d_rdata;
        ifAckNxt     = 1'b0;
        ifErrNxt     = 1'b0;
        dAckNxt      = 1'b0;
        dErrNxt      = 1'b0;
        memEnNxt     = mem_en;
        memWeNxt     = mem_we;
        memAddrNxt   = mem_addr;
        memWdataNxt  = mem_wdata;
        memBeNxt     = mem_be;
        lastGrantNxt = lastGrantData;
        cntNxt       = cnt;
        case (state)
            IDLE: begin
                if (grantI) begin
                    memEnNxt     = 1'b1;
                    memWeNxt     = 1'b0;
                    memAddrNxt   = if_addr;
                    memBeNxt     = '1;
                    lastGrantNxt = 1'b0;
                    cntNxt       = '0;
                end else if (grantD) begin
                    memEnNxt     = 1'b1;
                    memWeNxt     = d_we;
                    memAddrNxt   = d_addr;
                    memWdataNxt  = d_wdata;
                    memBeNxt     = d_be;
                    lastGrantNxt = 1'b1;
                    cntNxt       = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // mem_ready takes priority over a coincident timeout.
                if (mem_ready) begin
                    memEnNxt = 1'b0;
                    memWeNxt = 1'b0;
                    if (state == BUSY_I) begin
                        ifAckNxt   = 1'b1;
                        ifRdataNxt = mem_rdata;
                    end else begin
                        dAckNxt = 1'b1;
                        if (!mem_we) dRdataNxt = mem_rdata;
                    end
                end else if (timeoutHit) begin
                    memEnNxt = 1'b0;
                    memWeNxt = 1'b0;
                    if (state == BUSY_I) begin
                        ifAckNxt   = 1'b1;
                        ifErrNxt   = 1'b1;
                        ifRdataNxt = '0;
                    end else begin
                        dAckNxt   = 1'b1;
                        dErrNxt   = 1'b1;
                        dRdataNxt = '0;
                    end
                end else begin
                    cntNxt = cnt + CW'(1);
                end
            end
            default: ;
        endcase
        busyNxt = (nextState != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata      <= '0;
            if_ack        <= 1'b0;
            if_err        <= 1'b0;
            d_rdata       <= '0;
            d_ack         <= 1'b0;
            d_err         <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            busy          <= 1'b0;
            lastGrantData <= 1'b1;
            cnt           <= '0;
        end else begin
            if_rdata      <= ifRdataNxt;
            if_ack        <= ifAckNxt;
            if_err        <= ifErrNxt;
            d_rdata       <= dRdataNxt;
            d_ack         <= dAckNxt;
            d_err         <= dErrNxt;
            mem_en        <= memEnNxt;
            mem_we        <= memWeNxt;
            mem_addr      <= memAddrNxt;
            mem_wdata     <= memWdataNxt;
            mem_be        <= memBeNxt;
            busy          <= busyNxt;
            lastGrantData <= lastGrantNxt;
            cnt           <= cntNxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_ack, if_err;
    logic             d_req, d_we;
    logic [WIDTH-1:0] d_addr, d_wdata, d_rdata;
    logic [3:0]       d_be;
    logic             d_ack, d_err;
    logic             mem_en, mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_be;
    logic             mem_ready;
    logic             busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 0;
        tick(); tick();
        chk("rst mem_en", 32'(mem_en), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst acks", {30'd0, if_ack, d_ack}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst if_rdata", if_rdata, 0);
        reset = 1'b1;

        // single fetch, memory ready one cycle after mem_en
        if_req = 1; if_addr = 32'h100;
        tick();
        chk("f1 mem_en", 32'(mem_en), 1);
        chk("f1 mem_we", 32'(mem_we), 0);
        chk("f1 mem_be", 32'(mem_be), 32'hF);
        chk("f1 mem_addr", mem_addr, 32'h100);
        chk("f1 busy", 32'(busy), 1);
        chk("f1 no ack yet", 32'(if_ack), 0);
        mem_ready = 1; mem_rdata = 32'h00500093;
        tick();
        chk("f1 if_ack", 32'(if_ack), 1);
        chk("f1 if_err", 32'(if_err), 0);
        chk("f1 if_rdata", if_rdata, 32'h00500093);
        chk("f1 mem_en off", 32'(mem_en), 0);
        chk("f1 busy off", 32'(busy), 0);
        if_req = 0; mem_ready = 0; mem_rdata = '0;
        tick();
        chk("f1 ack one cycle", 32'(if_ack), 0);
        chk("f1 rdata held", if_rdata, 32'h00500093);

        // store byte, memory ready after three cycles
        d_req = 1; d_we = 1; d_addr = 32'h204; d_wdata = 32'hAB; d_be = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st mem_en", 32'(mem_en), 1);
            chk("st mem_we", 32'(mem_we), 1);
            chk("st mem_addr", mem_addr, 32'h204);
            chk("st mem_wdata", mem_wdata, 32'hAB);
            chk("st mem_be", 32'(mem_be), 32'h1);
            chk("st no ack", 32'(d_ack), 0);
            if (i == 2) begin
                mem_ready = 1; mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        chk("st d_ack", 32'(d_ack), 1);
        chk("st d_err", 32'(d_err), 0);
        chk("st d_rdata unchanged", d_rdata, 0);
        chk("st mem_en off", 32'(mem_en), 0);
        chk("st mem_we off", 32'(mem_we), 0);
        d_req = 0; d_we = 0; mem_ready = 0;
        tick();

        // simultaneous requests after a fresh reset, memory always ready
        reset = 0; tick(); reset = 1;
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h400; d_be = 4'hF;
        mem_ready = 1; mem_rdata = 32'hA1;
        tick();
        chk("rr g1 addr", mem_addr, 32'h300);
        chk("rr g1 en", 32'(mem_en), 1);
        tick();
        chk("rr g1 if_ack", 32'(if_ack), 1);
        chk("rr g1 if_rdata", if_rdata, 32'hA1);
        chk("rr g1 mem_en off", 32'(mem_en), 0);
        mem_rdata = 32'hB2;
        tick();
        chk("rr g2 addr", mem_addr, 32'h400);
        chk("rr g2 en", 32'(mem_en), 1);
        tick();
        chk("rr g2 d_ack", 32'(d_ack), 1);
        chk("rr g2 d_rdata", d_rdata, 32'hB2);
        mem_rdata = 32'hC3;
        tick();
        chk("rr g3 addr", mem_addr, 32'h300);
        chk("rr g3 en", 32'(mem_en), 1);
        chk("rr g3 d_ack off", 32'(d_ack), 0);
        tick();
        chk("rr g3 if_ack", 32'(if_ack), 1);
        chk("rr g3 if_rdata", if_rdata, 32'hC3);
        d_req = 0;
        tick();
        chk("own ack masked en", 32'(mem_en), 0);
        chk("own ack masked busy", 32'(busy), 0);
        tick();
        chk("regrant after mask", 32'(mem_en), 1);
        tick();
        chk("regrant ack", 32'(if_ack), 1);
        if_req = 0; mem_ready = 0;
        tick();

        // watchdog: memory never answers
        if_req = 1; if_addr = 32'h500; mem_rdata = 32'hFFFFFFFF;
        tick();
        chk("to en start", 32'(mem_en), 1);
        for (int i = 1; i < TIMEOUT; i++) tick();
        chk("to en still high", 32'(mem_en), 1);
        chk("to no early ack", 32'(if_ack), 0);
        tick();
        chk("to mem_en off", 32'(mem_en), 0);
        chk("to if_ack", 32'(if_ack), 1);
        chk("to if_err", 32'(if_err), 1);
        chk("to if_rdata", if_rdata, 0);
        if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h600; d_be = 4'hF;
        tick();
        chk("to err pulse", 32'(if_err), 0);
        chk("after to grant", mem_addr, 32'h600);
        chk("after to en", 32'(mem_en), 1);
        mem_ready = 1; mem_rdata = 32'h12345678;
        tick();
        chk("after to d_ack", 32'(d_ack), 1);
        chk("after to d_err", 32'(d_err), 0);
        chk("after to d_rdata", d_rdata, 32'h12345678);
        d_req = 0; mem_ready = 0;
        tick();

        // asynchronous reset in the middle of a data access
        d_req = 1; d_we = 1; d_addr = 32'h700; d_wdata = 32'h55; d_be = 4'b0011;
        tick();
        chk("ar busy", 32'(busy), 1);
        if_req = 1; if_addr = 32'h800;
        #2 reset = 0;
        #1;
        chk("ar mem_en", 32'(mem_en), 0);
        chk("ar mem_addr", mem_addr, 0);
        chk("ar mem_wdata", mem_wdata, 0);
        chk("ar mem_be/we", {27'd0, mem_be, mem_we}, 0);
        chk("ar busy off", 32'(busy), 0);
        chk("ar d_rdata", d_rdata, 0);
        chk("ar if_rdata", if_rdata, 0);
        tick();
        chk("ar no d_ack", 32'(d_ack), 0);
        reset = 1;
        tick();
        chk("ar fetch first", mem_addr, 32'h800);
        chk("ar fetch we", 32'(mem_we), 0);
        mem_ready = 1; mem_rdata = 32'h0A0A0A0A;
        tick();
        chk("ar if_ack", 32'(if_ack), 1);
        chk("ar d_ack idle", 32'(d_ack), 0);
        if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        tick();
        tick();

        // mem_ready while idle, then a load whose request drops mid-access
        mem_ready = 1; mem_rdata = 32'h99999999;
        tick();
        chk("idle rdy if_ack", 32'(if_ack), 0);
        chk("idle rdy d_ack", 32'(d_ack), 0);
        chk("idle rdy busy", 32'(busy), 0);
        chk("idle rdy if_rdata", if_rdata, 32'h0A0A0A0A);
        mem_ready = 0;
        d_req = 1; d_we = 0; d_addr = 32'h900; d_be = 4'hF;
        tick();
        chk("drop en", 32'(mem_en), 1);
        d_req = 0;
        tick();
        chk("drop still busy", 32'(mem_en), 1);
        chk("drop no ack yet", 32'(d_ack), 0);
        mem_ready = 1; mem_rdata = 32'h77;
        tick();
        chk("drop d_ack", 32'(d_ack), 1);
        chk("drop d_rdata", d_rdata, 32'h77);
        mem_ready = 0;
        tick();
        chk("drop single ack", 32'(d_ack), 0);
        chk("drop idle", 32'(mem_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
